// File: rtl/insn_fetch_queue.sv
// Instruction fetch front end: owns the PC, issues one request per cycle to a synchronous
// instruction memory and buffers responses in a prefetch FIFO. Optional: FETCH_BYPASS_EN.
module insn_fetch_queue #(
  parameter int unsigned MEM_INSN_ADDR = 16,
  parameter int unsigned LEN_INSN = 32,
  parameter int unsigned DEPTH = 4,
  parameter logic [MEM_INSN_ADDR-1:0] RESET_ADDR = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req_o,
  output logic [MEM_INSN_ADDR-1:0] imem_addr_o,
  input  logic [LEN_INSN-1:0]      imem_data_i,
  input  logic                     redirect_i,
  input  logic                     redirect_rel_i,
  input  logic [MEM_INSN_ADDR-1:0] redirect_base_i,
  input  logic [MEM_INSN_ADDR-1:0] redirect_off_i,
  output logic                     valid_o,
  output logic [LEN_INSN-1:0]      insn_o,
  output logic [MEM_INSN_ADDR-1:0] pc_o,
  input  logic                     stall_i,
  output logic                     stall_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [MEM_INSN_ADDR-1:0] pc_q, pc_d;
  logic [MEM_INSN_ADDR-1:0] tag_q, tag_d;
  logic                     inflight_q, inflight_d;
  logic                     kill_q, kill_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]         count_q, count_d;

  logic [LEN_INSN-1:0]      insn_mem [DEPTH];
  logic [MEM_INSN_ADDR-1:0] pc_mem   [DEPTH];

  logic [CNT_W-1:0]         occupancy;
  logic [MEM_INSN_ADDR-1:0] target;
  logic                     fifo_empty;
  logic                     fifo_full;
  logic                     req;
  logic                     resp_live;
  logic                     bypass;
  logic                     push;
  logic                     pop;

  // Occupancy reserves a slot for the in-flight response so it can never overflow the FIFO.
  assign occupancy  = count_q + CNT_W'(inflight_q);
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(DEPTH));
  assign target     = redirect_rel_i ? (redirect_base_i + redirect_off_i) : redirect_off_i;
  assign req        = rst && !redirect_i && (occupancy < CNT_W'(DEPTH));
  assign resp_live  = inflight_q && !kill_q && !redirect_i;

`ifdef FETCH_BYPASS_EN
  assign bypass = fifo_empty && resp_live && !stall_i;
`else
  assign bypass = 1'b0;
`endif

  assign push = resp_live && !bypass;
  assign pop  = !fifo_empty && !stall_i;

  always_comb begin
    pc_d       = pc_q;
    tag_d      = tag_q;
    inflight_d = req;
    kill_d     = redirect_i && inflight_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (req) begin
      tag_d = pc_q;
    end
    if (redirect_i) begin
      // Redirect wins over any push or pop in the same cycle.
      pc_d     = target;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (req) begin
        pc_d = pc_q + MEM_INSN_ADDR'(1);
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q       <= RESET_ADDR;
      tag_q      <= '0;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
      kill_q     <= kill_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      insn_mem[wr_ptr_q] <= imem_data_i;
      pc_mem[wr_ptr_q]   <= tag_q;
    end
  end

  always_comb begin
    valid_o = 1'b0;
    insn_o  = '0;
    pc_o    = '0;
    if (bypass) begin
      valid_o = 1'b1;
      insn_o  = imem_data_i;
      pc_o    = tag_q;
    end else if (!fifo_empty) begin
      valid_o = 1'b1;
      insn_o  = insn_mem[rd_ptr_q];
      pc_o    = pc_mem[rd_ptr_q];
    end
  end

  assign imem_req_o  = req;
  assign imem_addr_o = pc_q;
  assign stall_o     = fifo_full;

endmodule
